// File: rtl/addr2_write_pos.sv
// Tic-tac-toe cell decoder: 4-bit address to one-hot write mask, with optional
// occupancy tracking enabled by ADDR2_WRITE_POS_OCCUPANCY_EN.
module addr2_write_pos (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic       write,
  input  logic       clear,
  output logic [8:0] writePos,
  output logic       valid,
  output logic       conflict,
  output logic [8:0] occupied,
  output logic       full
);

  always_comb begin
    valid    = (addr < 4'd9);
    writePos = '0;
    if (valid) begin
      writePos = 9'b1 << addr;
    end
  end

`ifdef ADDR2_WRITE_POS_OCCUPANCY_EN

  logic [8:0] occupied_q;
  logic [8:0] occupied_d;

  // Conflict looks at pre-edge occupancy so a repeat move is flagged before it is dropped.
  always_comb begin
    conflict   = write & valid & (|(writePos & occupied_q));
    full       = &occupied_q;
    occupied_d = occupied_q;
    if (clear) begin
      occupied_d = '0;
    end else if (write && valid && !conflict) begin
      occupied_d = occupied_q | writePos;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occupied_q <= '0;
    end else begin
      occupied_q <= occupied_d;
    end
  end

  assign occupied = occupied_q;

`else

  // Pure decoder build: control inputs are retained as ports but have no effect.
  logic unused_inputs;
  assign unused_inputs = ^{clk, reset, write, clear};

  assign conflict = 1'b0;
  assign occupied = '0;
  assign full     = 1'b0;

`endif

endmodule

// File: tb/tb_addr2_write_pos.sv
// Directed self-checking bench for addr2_write_pos; expectations follow the
// build configuration (ADDR2_WRITE_POS_OCCUPANCY_EN defined or not).
module tb_addr2_write_pos;

`ifdef ADDR2_WRITE_POS_OCCUPANCY_EN
  localparam bit Occ = 1'b1;
`else
  localparam bit Occ = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] addr;
  logic       write;
  logic       clear;
  logic [8:0] writePos;
  logic       valid;
  logic       conflict;
  logic [8:0] occupied;
  logic       full;

  int n_checks = 0;
  int n_fail   = 0;

  addr2_write_pos dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .write    (write),
    .clear    (clear),
    .writePos (writePos),
    .valid    (valid),
    .conflict (conflict),
    .occupied (occupied),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] occ_exp(input logic [8:0] v);
    return Occ ? v : 9'b0;
  endfunction

  logic [8:0] exp_pos;

  initial begin
    reset = 1'b0;
    write = 1'b1;
    addr  = 4'd3;
    clear = 1'b0;
    #1;
    tick();
    check("reset_occupied", occupied, 9'b0);
    check("reset_full", {8'b0, full}, 9'b0);
    check("reset_writepos", writePos, 9'b000001000);

    // Combinational decode sweep, write idle.
    reset = 1'b1;
    write = 1'b0;
    for (int a = 0; a < 16; a++) begin
      addr = a[3:0];
      #1;
      exp_pos = (a < 9) ? (9'b1 << a) : 9'b0;
      check($sformatf("sweep_pos_%0d", a), writePos, exp_pos);
      check($sformatf("sweep_valid_%0d", a), {8'b0, valid}, (a < 9) ? 9'd1 : 9'd0);
      check($sformatf("sweep_conflict_%0d", a), {8'b0, conflict}, 9'b0);
    end

    // Write 4 then 0.
    tick();
    addr  = 4'd4;
    write = 1'b1;
    #1;
    check("w4_conflict", {8'b0, conflict}, 9'b0);
    tick();
    check("w4_occupied", occupied, occ_exp(9'b000010000));
    addr = 4'd0;
    tick();
    write = 1'b0;
    #1;
    check("w40_occupied", occupied, occ_exp(9'b000010001));

    // Repeat write to 4 is flagged and dropped.
    addr  = 4'd4;
    write = 1'b1;
    #1;
    check("repeat_conflict", {8'b0, conflict}, {8'b0, Occ});
    tick();
    check("repeat_occupied", occupied, occ_exp(9'b000010001));

    // Out-of-range write is dropped silently.
    addr = 4'd12;
    #1;
    check("oor_valid", {8'b0, valid}, 9'b0);
    check("oor_conflict", {8'b0, conflict}, 9'b0);
    check("oor_writepos", writePos, 9'b0);
    tick();
    check("oor_occupied", occupied, occ_exp(9'b000010001));

    // Clear, then fill all nine cells.
    write = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    check("clear_occupied", occupied, 9'b0);
    write = 1'b1;
    for (int a = 0; a < 9; a++) begin
      addr = a[3:0];
      #1;
      check($sformatf("fill_full_before_%0d", a), {8'b0, full}, 9'b0);
      tick();
    end
    write = 1'b0;
    #1;
    check("fill_occupied", occupied, occ_exp(9'h1FF));
    check("fill_full", {8'b0, full}, {8'b0, Occ});
    addr  = 4'd7;
    write = 1'b1;
    #1;
    check("full_conflict", {8'b0, conflict}, {8'b0, Occ});

    // Clear beats a simultaneous write.
    addr  = 4'd4;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    write = 1'b0;
    #1;
    check("clrwr_occupied", occupied, 9'b0);
    check("clrwr_full", {8'b0, full}, 9'b0);

    // Occupy five cells, then reset mid-game with a write pending.
    write = 1'b1;
    for (int a = 0; a < 5; a++) begin
      addr = a[3:0];
      tick();
    end
    write = 1'b0;
    #1;
    check("five_occupied", occupied, occ_exp(9'b000011111));
    reset = 1'b0;
    write = 1'b1;
    addr  = 4'd6;
    #1;
    check("rst_writepos", writePos, 9'b001000000);
    check("rst_valid", {8'b0, valid}, 9'd1);
    tick();
    check("midrst_occupied", occupied, 9'b0);
    check("midrst_full", {8'b0, full}, 9'b0);
    addr = 4'd8;
    #1;
    check("rst_writepos8", writePos, 9'b100000000);
    reset = 1'b1;
    write = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
